// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C round-robin bus arbiter.
package i2c_arb_pkg;

  localparam int unsigned DEF_N_MASTERS      = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;
  localparam int unsigned DEF_GUARD_CYCLES   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } arb_state_t;

  // Bits needed to index n items; never less than 1.
  function automatic int unsigned clog2_w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/i2c_rr_arbiter_n_rr_pick.sv
// Rotating-priority picker: first set request bit after last_id, with wrap.
module rr_pick
  import i2c_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS = DEF_N_MASTERS
) (
  input  logic [N_MASTERS-1:0]          req,
  input  logic [clog2_w(N_MASTERS)-1:0] last_id,
  output logic                          valid,
  output logic [clog2_w(N_MASTERS)-1:0] id
);

  localparam int unsigned ID_W = clog2_w(N_MASTERS);

  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int unsigned k = 1; k <= N_MASTERS; k++) begin
      logic [ID_W-1:0] sel;
      sel = ID_W'((32'(last_id) + k) % N_MASTERS);
      if (!valid && req[sel]) begin
        valid = 1'b1;
        id    = sel;
      end
    end
  end

endmodule

// File: rtl/i2c_rr_arbiter_n.sv
// Round-robin bus arbiter for N I2C masters with guard gap and grant watchdog.
module i2c_rr_arbiter_n
  import i2c_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS      = DEF_N_MASTERS,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned GUARD_CYCLES   = DEF_GUARD_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_MASTERS-1:0]          req,
  input  logic [N_MASTERS-1:0]          done,
  output logic [N_MASTERS-1:0]          grant,
  output logic [clog2_w(N_MASTERS)-1:0] grant_id,
  output logic                          busy,
  output logic                          timeout,
  output logic [clog2_w(N_MASTERS)-1:0] timeout_id
);

  localparam int unsigned ID_W       = clog2_w(N_MASTERS);
  localparam int unsigned WD_W       = clog2_w(TIMEOUT_CYCLES + 1);
  localparam int unsigned WD_LAST    = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam int unsigned GUARD_LAST = (GUARD_CYCLES == 0) ? 0 : GUARD_CYCLES - 1;
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_MASTERS - 1);

  arb_state_t           state, state_nxt;
  logic [N_MASTERS-1:0] grant_nxt;
  logic [ID_W-1:0]      grant_id_nxt;
  logic                 timeout_nxt;
  logic [ID_W-1:0]      timeout_id_nxt;
  logic [WD_W-1:0]      wdog, wdog_nxt;
  logic [3:0]           gcnt, gcnt_nxt;
  logic [ID_W-1:0]      last_id, last_id_nxt;

  logic                 pick_valid;
  logic [ID_W-1:0]      pick_id;
  logic                 own_done;
  logic                 own_req;
  logic                 expiry;

  rr_pick #(
    .N_MASTERS (N_MASTERS)
  ) u_pick (
    .req     (req),
    .last_id (last_id),
    .valid   (pick_valid),
    .id      (pick_id)
  );

  assign busy = (state == ST_GRANT) || (state == ST_GUARD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant      <= '0;
      grant_id   <= '0;
      timeout    <= 1'b0;
      timeout_id <= '0;
      wdog       <= '0;
      gcnt       <= '0;
      last_id    <= LAST_RST;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      grant_id   <= grant_id_nxt;
      timeout    <= timeout_nxt;
      timeout_id <= timeout_id_nxt;
      wdog       <= wdog_nxt;
      gcnt       <= gcnt_nxt;
      last_id    <= last_id_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    grant_id_nxt   = grant_id;
    timeout_nxt    = 1'b0;
    timeout_id_nxt = timeout_id;
    wdog_nxt       = wdog;
    gcnt_nxt       = gcnt;
    last_id_nxt    = last_id;

    own_done = done[grant_id];
    own_req  = req[grant_id];
    expiry   = (TIMEOUT_CYCLES != 0) && (wdog == WD_W'(WD_LAST));

    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_nxt    = ST_GRANT;
          grant_nxt    = N_MASTERS'(1) << pick_id;
          grant_id_nxt = pick_id;
          wdog_nxt     = '0;
        end
      end
      ST_GRANT: begin
        if (own_done || !own_req || expiry) begin
          // A master that finishes or withdraws on the expiry cycle is a normal release.
          timeout_nxt  = expiry && !own_done && own_req;
          if (timeout_nxt) timeout_id_nxt = grant_id;
          grant_nxt    = '0;
          grant_id_nxt = '0;
          last_id_nxt  = grant_id;
          gcnt_nxt     = '0;
          state_nxt    = (GUARD_CYCLES == 0) ? ST_IDLE : ST_GUARD;
        end else begin
          wdog_nxt = wdog + WD_W'(1);
        end
      end
      ST_GUARD: begin
        if (gcnt == 4'(GUARD_LAST)) state_nxt = ST_IDLE;
        else                        gcnt_nxt  = gcnt + 4'd1;
      end
      default: begin
        state_nxt    = ST_IDLE;
        grant_nxt    = '0;
        grant_id_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_rr_arbiter_n.sv
// Self-checking bench for i2c_rr_arbiter_n against a behavioural arbiter model.
module tb_i2c_rr_arbiter_n;

  localparam int N = 4;
  localparam int G = 2;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_i = '0;
  logic [3:0] done_i = '0;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;
  logic [1:0] timeout_id;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Model: who owns the bus, how long, remaining gap, last winner, last revoke.
  int m_owner, m_held, m_gap, m_last, m_tid;
  bit m_to;

  i2c_rr_arbiter_n #(
    .N_MASTERS      (N),
    .TIMEOUT_CYCLES (T),
    .GUARD_CYCLES   (G)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req_i),
    .done       (done_i),
    .grant      (grant),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout    (timeout),
    .timeout_id (timeout_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_gap = 0; m_last = N - 1; m_tid = 0; m_to = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic [3:0] d);
    bit fin, gone, exp;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      fin  = d[m_owner];
      gone = !r[m_owner];
      exp  = (T != 0) && (m_held == T - 1);
      if (fin || gone || exp) begin
        if (exp && !fin && !gone) begin
          m_to  = 1'b1;
          m_tid = m_owner;
        end
        m_last  = m_owner;
        m_owner = -1;
        m_gap   = G;
      end else begin
        m_held++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (r != 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (m_owner < 0 && r[c]) begin
          m_owner = c;
          m_held  = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] eg;
    eg = (m_owner >= 0) ? (4'd1 << m_owner) : 4'd0;
    chk({tag, "/grant"},      grant,      eg);
    chk({tag, "/grant_id"},   grant_id,   (m_owner >= 0) ? m_owner : 0);
    chk({tag, "/busy"},       busy,       (m_owner >= 0 || m_gap > 0) ? 1 : 0);
    chk({tag, "/timeout"},    timeout,    m_to);
    chk({tag, "/timeout_id"}, timeout_id, m_tid);
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] d, input string tag);
    req_i  = r;
    done_i = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    req_i  = '0;
    done_i = '0;
    #2;
    model_reset();
    check_all("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit got=running exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int order[$];
    int since, guard_run;
    bit prev_g;
    logic [3:0] r, d;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    model_reset();
    do_reset();

    // First request from masters 1 and 3: master 1 is first after last_id=3.
    step(4'b1010, 4'b0000, "s1");
    chk("s1_grant", grant, 4'b0010);
    chk("s1_id", grant_id, 1);
    step(4'b0000, 4'b0000, "s1rel");

    // All masters requesting, done three cycles after each grant.
    do_reset();
    since = 0; guard_run = 0; prev_g = 1'b0;
    for (int cyc = 0; cyc < 80 && order.size() < 5; cyc++) begin
      d = (grant != 0 && since == 3) ? grant : 4'b0000;
      step(4'b1111, d, "s2");
      if (grant != 0 && !prev_g) begin
        if (order.size() > 0) chk("s2_guard_len", guard_run, G);
        order.push_back(int'(grant_id));
        since = 0;
        guard_run = 0;
      end else if (grant != 0) begin
        since++;
      end else if (busy) begin
        guard_run++;
      end
      prev_g = (grant != 0);
    end
    chk("s2_count", order.size(), 5);
    for (int i = 0; i < 5 && i < order.size(); i++) chk("s2_order", order[i], exp_order[i]);

    // Single request timing: grant at t+1, release at t+6, busy to t+7, regrant t+9.
    do_reset();
    step(4'b0100, 4'b0000, "s3");
    chk("s3_grant_t1", grant, 4'b0100);
    for (int i = 0; i < 4; i++) step(4'b0100, 4'b0000, "s3");
    step(4'b0100, 4'b0100, "s3");
    chk("s3_rel_t6", grant, 4'b0000);
    step(4'b0100, 4'b0000, "s3");
    chk("s3_busy_t7", busy, 1);
    step(4'b0100, 4'b0000, "s3");
    chk("s3_grant_t8", grant, 4'b0000);
    step(4'b0100, 4'b0000, "s3");
    chk("s3_grant_t9", grant, 4'b0100);

    // Watchdog revokes master 1 after 16 grant cycles; master 2 is next.
    do_reset();
    step(4'b0110, 4'b0000, "s4");
    chk("s4_first", grant_id, 1);
    for (int i = 0; i < T - 1; i++) begin
      step(4'b0110, 4'b0000, "s4");
      chk("s4_hold_to", timeout, 0);
    end
    step(4'b0110, 4'b0000, "s4");
    chk("s4_timeout", timeout, 1);
    chk("s4_tid", timeout_id, 1);
    chk("s4_grant0", grant, 4'b0000);
    step(4'b0110, 4'b0000, "s4");
    chk("s4_pulse", timeout, 0);
    for (int i = 0; i < 10 && grant == 0; i++) step(4'b0110, 4'b0000, "s4");
    chk("s4_next", grant, 4'b0100);
    chk("s4_tid_held", timeout_id, 1);

    // done on the expiry cycle wins: no timeout pulse.
    do_reset();
    step(4'b0010, 4'b0000, "s5");
    for (int i = 0; i < T - 1; i++) step(4'b0010, 4'b0000, "s5");
    step(4'b0010, 4'b0010, "s5");
    chk("s5_no_to", timeout, 0);
    chk("s5_rel", grant, 4'b0000);

    // Foreign done ignored; dropping req releases without timeout.
    do_reset();
    step(4'b0001, 4'b0000, "s6");
    step(4'b0001, 4'b1000, "s6");
    chk("s6_ignore", grant, 4'b0001);
    step(4'b0000, 4'b0000, "s6");
    chk("s6_rel", grant, 4'b0000);
    chk("s6_no_to", timeout, 0);

    // Asynchronous reset mid-grant, then master 0 wins.
    do_reset();
    step(4'b0100, 4'b0000, "s7");
    step(4'b0100, 4'b0000, "s7");
    #2;
    rst_n = 1'b0;
    #1;
    chk("s7_async_grant", grant, 4'b0000);
    chk("s7_async_busy", busy, 0);
    chk("s7_async_to", timeout, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'b1111, 4'b0000, "s7");
    chk("s7_master0", grant, 4'b0001);

    // Randomized traffic against the model.
    do_reset();
    r = 4'($urandom);
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 11) == 0) r[b] = ~r[b];
      d = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      step(r, d, "rnd");
      if (cyc == 300) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
